tamagotchi_action_scheduler: RTL

Sequences every update to the pet's six stat registers. Button presses (feed, play, clean, sleep, heal, socialize) and a periodic decay tick become one command stream to the stats datapath. The block sits between the raw input switches and the stats update logic. It arbitrates these requests, enforces a cooldown between user actions, and issues exactly one command at a time over a valid/ready handshake.

---
 rtl/tamagotchi_pkg.sv | 35 +++
 rtl/btn_sync_edge.sv | 29 ++
 rtl/tamagotchi_action_scheduler.sv | 121 ++++++++++++
 3 files changed

// File: rtl/tamagotchi_pkg.sv
// Shared op encoding, action count and scheduler FSM states for the pet stat path.
package tamagotchi_pkg;

  localparam int unsigned NUM_ACTIONS = 6;
  localparam int unsigned OP_W        = 3;
  localparam int unsigned PEND_W      = NUM_ACTIONS + 1;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_DECAY  = 3'd0;
  localparam op_t OP_FEED   = 3'd1;
  localparam op_t OP_PLAY   = 3'd2;
  localparam op_t OP_CLEAN  = 3'd3;
  localparam op_t OP_SLEEP  = 3'd4;
  localparam op_t OP_HEAL   = 3'd5;
  localparam op_t OP_SOCIAL = 3'd6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Map a button index (0 = feed .. 5 = socialize) to its command op.
  function automatic op_t action_op(input logic [2:0] idx);
    case (idx)
      3'd0:    action_op = OP_FEED;
      3'd1:    action_op = OP_PLAY;
      3'd2:    action_op = OP_CLEAN;
      3'd3:    action_op = OP_SLEEP;
      3'd4:    action_op = OP_HEAL;
      default: action_op = OP_SOCIAL;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector, one lane per input bit.
module btn_sync_edge #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise_c
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/tamagotchi_action_scheduler.sv
// Merges button actions and the periodic decay tick into one valid/ready command stream
// with decay priority, round-robin actions and a post-action cooldown.
module tamagotchi_action_scheduler
  import tamagotchi_pkg::*;
#(
  parameter logic [23:0] TICK_COUNT = 24'd10_000_000,
  parameter logic [15:0] COOLDOWN   = 16'd1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [NUM_ACTIONS-1:0] btn,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [OP_W-1:0]        cmd_op,
  output logic [PEND_W-1:0]      pending,
  output logic                   busy,
  output logic                   dropped
);

  logic [NUM_ACTIONS-1:0] rise_c;
  logic [NUM_ACTIONS-1:0] act_pend_c;
  logic [23:0]            tick_q;
  logic [15:0]            cd_q;
  logic [2:0]             last_q;
  state_t                 state_q, state_d;
  logic [PEND_W-1:0]      clr_c, set_c, pend_d;
  logic                   drop_d;
  logic                   hs_c, wrap_c, grant_en_c, found_c;
  logic [3:0]             rr_sum_c;
  op_t                    grant_c, op_d;
  logic                   valid_d;

  btn_sync_edge #(.WIDTH(NUM_ACTIONS)) u_btn_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (btn),
    .rise_c (rise_c)
  );

  assign busy       = (cd_q != 16'd0);
  assign hs_c       = (state_q == ST_ISSUE) && cmd_ready;
  assign wrap_c     = ena && (tick_q == TICK_COUNT - 24'd1);
  assign act_pend_c = pending[PEND_W-1:1];
  assign grant_en_c = ena && (pending != '0);

  // Request latching: rejection during cooldown, coalescing, and set-beats-clear.
  always_comb begin
    clr_c  = '0;
    set_c  = '0;
    drop_d = 1'b0;
    if (hs_c) clr_c[cmd_op] = 1'b1;
    set_c[0] = wrap_c;
    if (ena && !busy) set_c[PEND_W-1:1] = rise_c;
    if (ena && busy && (rise_c != '0)) drop_d = 1'b1;
    if ((set_c & pending & ~clr_c) != '0) drop_d = 1'b1;
    pend_d = (pending & ~clr_c) | set_c;
  end

  // Decay first, otherwise the first pending action after the last one served.
  always_comb begin
    grant_c  = OP_DECAY;
    found_c  = 1'b0;
    rr_sum_c = '0;
    if (!pending[0]) begin
      for (int unsigned k = 1; k <= NUM_ACTIONS; k++) begin
        rr_sum_c = 4'(last_q) + 4'(k);
        if (rr_sum_c >= 4'(NUM_ACTIONS)) rr_sum_c = rr_sum_c - 4'(NUM_ACTIONS);
        if (!found_c && act_pend_c[3'(rr_sum_c)]) begin
          found_c = 1'b1;
          grant_c = action_op(3'(rr_sum_c));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_en_c) state_d = ST_ISSUE;
      ST_ISSUE: if (cmd_ready)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = (state_d == ST_ISSUE);
    op_d    = cmd_op;
    if ((state_q == ST_IDLE) && grant_en_c) op_d = grant_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_op    <= OP_DECAY;
      pending   <= '0;
      dropped   <= 1'b0;
      tick_q    <= '0;
      cd_q      <= '0;
      last_q    <= 3'(NUM_ACTIONS - 1);
    end else begin
      cmd_valid <= valid_d;
      cmd_op    <= op_d;
      pending   <= pend_d;
      dropped   <= drop_d;
      if (ena) tick_q <= wrap_c ? 24'd0 : tick_q + 24'd1;
      if (hs_c && (cmd_op != OP_DECAY)) begin
        cd_q   <= COOLDOWN;
        last_q <= 3'(cmd_op - 3'd1);
      end else if (busy) begin
        cd_q <= cd_q - 16'd1;
      end
    end
  end

endmodule
